write_through_buffer: RTL and testbench
=======================================

// Module: write_through_buffer
// PURPOSE
//  Store buffer between the 4-way set-associative cache controller and main memory.
//  - Absorbs the controller's write-through stores so the controller does not stall on memory latency.
//  - Drains the stores to memory in order.
//  - Serves the controller's miss-fill reads, forwarding from buffered stores on an address match.
// PARAMETERS
//  DEPTH   4   buffer entries (power of 2, >=2)
//  ADDR_W  32  address width
//  DATA_W  32  data width
// PORTS
//  clk         in   1       clock, all state on posedge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       controller request valid
//  req_ready   out  1       request accepted when req_valid && req_ready at posedge
//  req_op      in   1       0 = read (miss fill), 1 = write (write-through store)
//  req_addr    in   ADDR_W  request address (full-width compare)
//  req_wdata   in   DATA_W  store data
//  resp_valid  out  1       one-cycle pulse, read data valid
//  resp_rdata  out  DATA_W  read data
//  mem_req     out  1       memory request, held until mem_ack
//  mem_we      out  1       1 = write, 0 = read; stable while mem_req
//  mem_addr    out  ADDR_W  memory address; stable while mem_req
//  mem_wdata   out  DATA_W  memory write data; stable while mem_req
//  mem_ack     in   1       one-cycle completion pulse from memory
//  mem_rdata   in   DATA_W  read data, valid with mem_ack
//  empty       out  1       no buffered stores and no access in flight
// BEHAVIOUR
//  Reset values: req_ready=1, resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, empty=1.
//  Reset is asynchronous at any time: FIFO, pointers, count and FSM clear; mem_req drops immediately; buffered stores are discarded.
//  FIFO: circular, wr_ptr/rd_ptr wrap at DEPTH, count 0..DEPTH.
//  req_ready = (count != DEPTH) && !rd_pending. It uses registered state only, so a pop in the same cycle does not reopen a full buffer.
//  Accepted write: enqueued at wr_ptr. A simultaneous enqueue and pop updates count by 0.
//  Accepted read, address hit in buffer (including the head in flight):
//   - resp_valid pulses the next cycle with the youngest matching data.
//   - No memory access is made.
//  Accepted read, miss: sets rd_pending (req_ready=0 until the response).
//   - Bypasses buffered stores; ordering is safe because no buffered store matches the address.
//  FSM states: IDLE, WR (head write in flight), RD (read in flight), RSP (response pulse).
//   - IDLE -> RD when rd_pending; else -> WR when count > 0. Reads have priority over drain.
//   - WR: mem_req=1, mem_we=1, address/data = head. On mem_ack: pop head, then -> RD if rd_pending, else -> WR if count_next > 0, else -> IDLE.
//   - RD: mem_req=1, mem_we=0. On mem_ack: register mem_rdata, -> RSP.
//   - RSP: resp_valid=1 for one cycle, clear rd_pending, -> IDLE.
//  Memory latency is arbitrary. A new mem_req is raised no earlier than the cycle after mem_ack.
//  Hit-response latency is 1 cycle. Miss-response latency is (wait for in-flight write) + mem latency + 1.
//  empty = (count == 0) && (state == IDLE) && !rd_pending.
// CONFIGURATION
//  WTB_COALESCE_EN:
//   - Defined: an accepted write whose address matches a buffered entry that is not the head in flight overwrites that entry's data; count is unchanged; the write is accepted even when the buffer is full.
//   - Undefined: every write allocates a new entry, and req_ready follows the rule above.
// TESTING
//  1. Reset, write 64=111, then 1088=222, mem_ack 3 cycles after each mem_req -> memory sees (64,111) then (1088,222); empty=1 the cycle after the 2nd ack.
//  2. mem_ack held low, 4 writes -> req_ready=0 after the 4th; 5th write stalls; one mem_ack -> req_ready=1 next cycle; the 5th write enqueues.
//  3. Write 2112=5000 with mem_ack held low, then read 2112 -> resp_valid next cycle with resp_rdata=5000; no mem_req with mem_we=0.
//  4. Buffer holds 1088, 3136 with 1088 in flight; read 64 (memory holds 111) -> read issues right after 1088 ack and before 3136; resp 111.
//  5. rst_n low while mem_req=1 and count=3 -> mem_req=0, resp_valid=0, empty=1, req_ready=1 without a clock edge.
//  6. Head busy; write 3136=333, then 3136=444 -> with WTB_COALESCE_EN, count rises by 1 and memory sees 3136=444 once; without it, memory sees 333 then 444.

Source files
------------

// File: rtl/write_through_buffer_if.sv
// Controller request/response and memory bus bundle for write_through_buffer.
// The buffer itself attaches through the slave modport.
interface write_through_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              empty;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, empty
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, empty
    );
endinterface

// File: rtl/write_through_buffer.sv
// In-order store buffer between cache controller and memory, with read forwarding.
// Optional macro WTB_COALESCE_EN merges a store into a matching buffered entry not yet in flight.
module write_through_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    write_through_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rd_pending;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;

    logic              w_hit;
    logic [PTR_W-1:0]  w_hit_idx;
    logic [PTR_W-1:0]  w_scan_idx;
    logic              w_scan_match;
    logic              w_coal;
    logic [PTR_W-1:0]  w_coal_idx;
    logic              w_full;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_acc_wr;
    logic              w_acc_rd;
    logic              w_enq;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;

    // Youngest valid entry whose address matches the request (head in flight included)
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_scan_idx   = '0;
        w_scan_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx   = r_rd_ptr + PTR_W'(k);
            w_scan_match = (CNT_W'(k) < r_count) && (r_fifo_addr[w_scan_idx] == bus.req_addr);
            w_hit        = w_hit | w_scan_match;
            w_hit_idx    = w_scan_match ? w_scan_idx : w_hit_idx;
        end
    end

    assign w_full = (r_count == CNT_W'(DEPTH));

`ifdef WTB_COALESCE_EN
    logic             w_coal_hit;
    logic [PTR_W-1:0] w_cscan_idx;
    logic             w_cscan_match;

    // Matching entry that may still be rewritten: anything except the head being written out
    always_comb begin
        w_coal_hit    = 1'b0;
        w_coal_idx    = r_wr_ptr;
        w_cscan_idx   = '0;
        w_cscan_match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_cscan_idx   = r_rd_ptr + PTR_W'(k);
            w_cscan_match = (CNT_W'(k) < r_count)
                          && (r_fifo_addr[w_cscan_idx] == bus.req_addr)
                          && !((k == 0) && (r_state == ST_WR));
            w_coal_hit    = w_coal_hit | w_cscan_match;
            w_coal_idx    = w_cscan_match ? w_cscan_idx : w_coal_idx;
        end
    end

    assign w_coal      = bus.req_op && w_coal_hit;
    assign w_req_ready = !r_rd_pending && (!w_full || w_coal);
`else
    assign w_coal      = 1'b0;
    assign w_coal_idx  = r_wr_ptr;
    assign w_req_ready = !r_rd_pending && !w_full;
`endif

    assign w_accept     = bus.req_valid && w_req_ready;
    assign w_acc_wr     = w_accept && bus.req_op;
    assign w_acc_rd     = w_accept && !bus.req_op;
    assign w_enq        = w_acc_wr && !w_coal;
    assign w_pop        = (r_state == ST_WR) && bus.mem_ack;
    assign w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_pop);

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_fifo_addr[r_wr_ptr] <= bus.req_addr;
                r_fifo_data[r_wr_ptr] <= bus.req_wdata;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end else if (w_acc_wr && w_coal) begin
                r_fifo_data[w_coal_idx] <= bus.req_wdata;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Read handling: forwarded hits answer next cycle, misses wait for the memory read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pending <= 1'b0;
            r_rd_addr    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_acc_rd && w_hit) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= r_fifo_data[w_hit_idx];
            end else if ((r_state == ST_RD) && bus.mem_ack) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= bus.mem_rdata;
            end
            if (w_acc_rd && !w_hit) begin
                r_rd_pending <= 1'b1;
                r_rd_addr    <= bus.req_addr;
            end else if (r_state == ST_RSP) begin
                r_rd_pending <= 1'b0;
            end
        end
    end

    // Memory FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory FSM next state; a pending miss read outranks draining stores
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = r_rd_pending ? ST_RD
                                  : ((r_count != '0) ? ST_WR : ST_IDLE);
            ST_WR: begin
                if (bus.mem_ack) begin
                    w_state_next = r_rd_pending ? ST_RD
                                 : ((w_count_next != '0) ? ST_WR : ST_IDLE);
                end else begin
                    w_state_next = ST_WR;
                end
            end
            ST_RD:   w_state_next = bus.mem_ack ? ST_RSP : ST_RD;
            ST_RSP:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_req    = (r_state == ST_WR) || (r_state == ST_RD);
    assign bus.mem_we     = (r_state == ST_WR);
    assign bus.mem_addr   = (r_state == ST_WR) ? r_fifo_addr[r_rd_ptr]
                          : ((r_state == ST_RD) ? r_rd_addr : '0);
    assign bus.mem_wdata  = (r_state == ST_WR) ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.empty      = (r_count == '0) && (r_state == ST_IDLE) && !r_rd_pending;
endmodule

// File: tb/tb_write_through_buffer.sv
// Self-checking bench for write_through_buffer: directed scenarios plus randomized traffic
// against a reference where every read returns the latest value written to that address.
`timescale 1ns/1ps
module tb_write_through_buffer;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    write_through_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    write_through_buffer #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    logic [DW-1:0] mem_store [logic [AW-1:0]];
    logic [DW-1:0] ref_mem   [logic [AW-1:0]];
    op_t           op_log[$];
    op_t           exp_wr_q[$];
    logic [DW-1:0] exp_resp_q[$];

    int          m_lat        = 1;
    bit          m_stall      = 1'b0;
    int          m_credit     = 0;
    int          m_cnt        = 0;
    int          mem_reads    = 0;
    int unsigned last_ack_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: arbitrary latency, optional stall with single-ack credits
    initial begin
        op_t o;
        op_t e;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (!rst_n) begin
                m_cnt = 0;
            end else if (bus.mem_req && (!m_stall || m_credit > 0)) begin
                if (m_cnt >= m_lat) begin
                    m_cnt  = 0;
                    if (m_stall) m_credit--;
                    o.we   = bus.mem_we;
                    o.addr = bus.mem_addr;
                    o.data = bus.mem_we ? bus.mem_wdata : '0;
                    op_log.push_back(o);
                    if (bus.mem_we) begin
                        mem_store[bus.mem_addr] = bus.mem_wdata;
`ifndef WTB_COALESCE_EN
                        check("wr_expected", exp_wr_q.size() != 0, 1'b1);
                        if (exp_wr_q.size() != 0) begin
                            e = exp_wr_q.pop_front();
                            check("wr_order_addr", bus.mem_addr, e.addr);
                            check("wr_order_data", bus.mem_wdata, e.data);
                        end
`endif
                    end else begin
                        bus.mem_rdata = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr]
                                                                       : mem_init(bus.mem_addr);
                        mem_reads++;
                    end
                    bus.mem_ack  = 1'b1;
                    last_ack_cyc = cyc;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Response monitor: each resp_valid must match the oldest outstanding read
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.resp_valid) begin
                check("resp_expected", exp_resp_q.size() != 0, 1'b1);
                if (exp_resp_q.size() != 0) check("resp_data", bus.resp_rdata, exp_resp_q.pop_front());
            end
        end
    end

    // Entered at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int  n = 0;
        op_t w;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #1;
        while (!bus.req_ready && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        check("req_accepted", bus.req_ready, 1'b1);
        if (bus.req_ready) begin
            if (op) begin
                ref_mem[a] = d;
                w.we = 1'b1; w.addr = a; w.data = d;
                exp_wr_q.push_back(w);
            end else begin
                exp_resp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : mem_init(a));
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!bus.empty && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", bus.empty, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int          r0;
        int          n3136;
        logic [DW-1:0] first3136;
        logic [DW-1:0] last3136;
        logic        op;
        logic [AW-1:0] a;

        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #1;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_empty", bus.empty, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // 1: two stores drain in order with 3-cycle memory latency
        m_lat = 3;
        op_log.delete();
        send(1'b1, 32'd64, 32'd111);
        send(1'b1, 32'd1088, 32'd222);
        wait_empty();
        check("t1_empty_after_ack", cyc, last_ack_cyc + 1);
        check("t1_nops", op_log.size(), 2);
        if (op_log.size() >= 2) begin
            check("t1_op0", {op_log[0].we, op_log[0].addr, op_log[0].data}, {1'b1, 32'd64, 32'd111});
            check("t1_op1", {op_log[1].we, op_log[1].addr, op_log[1].data}, {1'b1, 32'd1088, 32'd222});
        end

        // 2: full buffer back-pressure, reopening one cycle after a single ack
        m_lat   = 0;
        m_stall = 1'b1;
        for (int k = 5; k < 9; k++) send(1'b1, 32'd64 + 32'd1024 * k, 32'h100 + k);
        check("t2_full", bus.req_ready, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b1;
        bus.req_addr  = 32'd9280;
        bus.req_wdata = 32'h109;
        idle(3);
        check("t2_stall", bus.req_ready, 1'b0);
        m_credit = 1;
        r0 = 0;
        #1;
        while (!bus.req_ready && r0 < 10) begin
            @(posedge clk); #2;
            r0++;
        end
        check("t2_reopen", bus.req_ready, 1'b1);
        check("t2_reopen_cycle", cyc, last_ack_cyc + 1);
        ref_mem[32'd9280] = 32'h109;
        exp_wr_q.push_back(op_t'{1'b1, 32'd9280, 32'h109});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        m_stall = 1'b0;
        wait_empty();
        check("t2_last_addr", op_log[op_log.size()-1].addr, 32'd9280);

        // 3: read hits a buffered store; answered next cycle with no memory read
        m_stall = 1'b1;
        r0      = mem_reads;
        send(1'b1, 32'd2112, 32'd5000);
        send(1'b0, 32'd2112, 32'd0);
        check("t3_hit_valid", bus.resp_valid, 1'b1);
        check("t3_hit_data", bus.resp_rdata, 32'd5000);
        m_stall = 1'b0;
        wait_empty();
        check("t3_no_mem_read", mem_reads, r0);

        // 4: miss read slips in after the in-flight store, ahead of the next store
        m_stall = 1'b1;
        send(1'b1, 32'd1088, 32'hA1);
        send(1'b1, 32'd3136, 32'hB1);
        send(1'b0, 32'd64, 32'd0);
        op_log.delete();
        m_stall = 1'b0;
        wait_empty();
        check("t4_nops", op_log.size(), 3);
        if (op_log.size() >= 3) begin
            check("t4_op0", {op_log[0].we, op_log[0].addr}, {1'b1, 32'd1088});
            check("t4_op1", {op_log[1].we, op_log[1].addr}, {1'b0, 32'd64});
            check("t4_op2", {op_log[2].we, op_log[2].addr}, {1'b1, 32'd3136});
        end

        // 5: asynchronous reset with a store in flight
        m_stall = 1'b1;
        send(1'b1, 32'd5184, 32'h51);
        send(1'b1, 32'd6208, 32'h52);
        send(1'b1, 32'd7232, 32'h53);
        idle(1);
        check("t5_busy", bus.mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_mem_req", bus.mem_req, 1'b0);
        check("t5_resp_valid", bus.resp_valid, 1'b0);
        check("t5_empty", bus.empty, 1'b1);
        check("t5_req_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_stall  = 1'b0;
        m_credit = 0;
        exp_wr_q.delete();
        exp_resp_q.delete();
        ref_mem.delete();
        foreach (mem_store[k]) ref_mem[k] = mem_store[k];
        idle(1);

        // 6: two stores to one address behind a busy head
        m_stall = 1'b1;
        send(1'b1, 32'd1088, 32'hC1);
        send(1'b1, 32'd3136, 32'd333);
        send(1'b1, 32'd3136, 32'd444);
        op_log.delete();
        m_stall = 1'b0;
        wait_empty();
        n3136     = 0;
        first3136 = '0;
        last3136  = '0;
        foreach (op_log[k]) begin
            if (op_log[k].we && op_log[k].addr == 32'd3136) begin
                if (n3136 == 0) first3136 = op_log[k].data;
                last3136 = op_log[k].data;
                n3136++;
            end
        end
`ifdef WTB_COALESCE_EN
        check("t6_writes", n3136, 1);
        check("t6_data", last3136, 32'd444);
`else
        check("t6_writes", n3136, 2);
        check("t6_first", first3136, 32'd333);
        check("t6_last", last3136, 32'd444);
`endif

        // Randomized mixed traffic over a small address pool to provoke hits
        for (int i = 0; i < 300; i++) begin
            m_lat = $urandom_range(0, 3);
            op    = ($urandom_range(0, 1) == 1);
            a     = 32'd64 + 32'd1024 * $urandom_range(0, 5);
            send(op, a, $urandom);
            idle($urandom_range(0, 2));
        end
        wait_empty();
        idle(2);
        foreach (ref_mem[k]) begin
            check("final_mem", mem_store.exists(k) ? mem_store[k] : mem_init(k), ref_mem[k]);
        end
        check("resp_all_seen", exp_resp_q.size(), 0);
`ifndef WTB_COALESCE_EN
        check("writes_all_seen", exp_wr_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
